// File: rtl/tone_player.sv
// tone_player: beat-stepped note player driving a square-wave speaker from a preset tone counter.
// Ports: CLK system clock; RST async active-low reset; TONE_CODE note code from the song ROM;
//        BEAT one-cycle beat pulse; SPKS speaker square wave; CODE note digit 0-7 (0 = rest);
//        HIGH octave (00 rest, 01 low, 10 mid, 11 high).
// Macro TONE_DISPLAY_EN builds the CODE/HIGH display registers; without it both outputs read 0.
module tone_player #(
    parameter int BEAT_DIV = 3000000,
    parameter int PRE_DIV  = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] TONE_CODE,
    output logic       BEAT,
    output logic       SPKS,
    output logic [3:0] CODE,
    output logic [1:0] HIGH
);
    localparam int BW = $clog2(BEAT_DIV);
    localparam int PW = PRE_DIV > 1 ? $clog2(PRE_DIV) : 1;
    localparam logic [10:0] TOP = 11'd2047;
    localparam logic [10:0] PRESET [32] = '{
        11'd2047,
        11'd773,  11'd912,  11'd1036, 11'd1116, 11'd1197, 11'd1290, 11'd1372,
        11'd1410, 11'd1480, 11'd1542, 11'd1622, 11'd1668, 11'd1728, 11'd1774,
        11'd1813, 11'd1854, 11'd1891, 11'd1905, 11'd1934, 11'd1961, 11'd1987,
        11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047,
        11'd2047, 11'd2047, 11'd2047, 11'd2047, 11'd2047
    };
    logic [BW-1:0] beat_q, beat_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [10:0]   tone_q, tone_d;
    logic [4:0]    note_q, note_d;
    logic          spks_q, spks_d, tick, silent;

    function automatic logic is_rest(input logic [4:0] c);
        return c == 5'd0 || c > 5'd21;
    endfunction

    assign BEAT = beat_q == BW'(BEAT_DIV - 1);
    assign tick = pre_q == PW'(PRE_DIV - 1);
    assign SPKS = spks_q;
    // Entering a rest silences at the latching edge itself; leaving a rest keeps the
    // counter parked at 2047 for that edge so the first later tick loads the new preset.
    assign silent = is_rest(note_q) || (BEAT && is_rest(TONE_CODE));

    always_comb begin
        beat_d = BEAT ? '0 : beat_q + 1'b1;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        note_d = BEAT ? TONE_CODE : note_q;
        tone_d = silent ? TOP : !tick ? tone_q : tone_q == TOP ? PRESET[note_q] : tone_q + 11'd1;
        spks_d = silent ? 1'b0 : (tick && tone_q == TOP) ? ~spks_q : spks_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            beat_q <= '0;
            pre_q  <= '0;
            tone_q <= TOP;
            note_q <= '0;
            spks_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            pre_q  <= pre_d;
            tone_q <= tone_d;
            note_q <= note_d;
            spks_q <= spks_d;
        end
    end

`ifdef TONE_DISPLAY_EN
    logic [3:0] code_q, code_d;
    logic [1:0] high_q, high_d;

    always_comb begin
        high_d = is_rest(note_q) ? 2'd0 : note_q < 5'd8 ? 2'd1 : note_q < 5'd15 ? 2'd2 : 2'd3;
        code_d = high_d == 2'd0 ? 4'd0 : high_d == 2'd1 ? note_q[3:0] :
                 high_d == 2'd2 ? 4'(note_q - 5'd7) : 4'(note_q - 5'd14);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            code_q <= '0;
            high_q <= '0;
        end else begin
            code_q <= code_d;
            high_q <= high_d;
        end
    end

    assign CODE = code_q;
    assign HIGH = high_q;
`else
    assign CODE = 4'd0;
    assign HIGH = 2'd0;
`endif
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed checks of beat timing, note presets, rests, note change and reset.
module tb_tone_player;
    localparam int BD = 8;
`ifdef TONE_DISPLAY_EN
    localparam bit DISP = 1'b1;
`else
    localparam bit DISP = 1'b0;
`endif
    logic       CLK = 1'b0, RST = 1'b1, BEAT, SPKS;
    logic [4:0] TONE_CODE = 5'd0;
    logic [3:0] CODE;
    logic [1:0] HIGH;
    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [4:0] code;
        int         half;
        logic [3:0] c;
        logic [1:0] h;
    } vec_t;
    vec_t tbl [12];

    tone_player #(.BEAT_DIV(BD), .PRE_DIV(1)) dut (
        .CLK(CLK), .RST(RST), .TONE_CODE(TONE_CODE),
        .BEAT(BEAT), .SPKS(SPKS), .CODE(CODE), .HIGH(HIGH)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat_seq(input string tag);
        for (int k = 1; k <= 3 * BD; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("%s beat after edge %0d", tag, k), int'(BEAT), int'((k % BD) == BD - 1));
        end
    endtask

    task automatic wait_latch();
        int n = 0;
        while (BEAT !== 1'b1 && n < 4 * BD) begin
            @(negedge CLK);
            n++;
        end
        chk("beat seen", int'(BEAT), 1);
        @(negedge CLK);
    endtask

    task automatic wait_toggle(output int n);
        logic s = SPKS;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (SPKS == s && n < 4000);
        if (n >= 4000) chk("toggle timeout", n, 0);
    endtask

    initial begin
        int n, t0, tries;
        bit quiet;
        tbl[0]  = '{5'd8,  638,  4'd1, 2'd2};
        tbl[1]  = '{5'd1,  1275, 4'd1, 2'd1};
        tbl[2]  = '{5'd7,  676,  4'd7, 2'd1};
        tbl[3]  = '{5'd14, 274,  4'd7, 2'd2};
        tbl[4]  = '{5'd15, 235,  4'd1, 2'd3};
        tbl[5]  = '{5'd21, 61,   4'd7, 2'd3};
        tbl[6]  = '{5'd0,  0,    4'd0, 2'd0};
        tbl[7]  = '{5'd11, 426,  4'd4, 2'd2};
        tbl[8]  = '{5'd25, 0,    4'd0, 2'd0};
        tbl[9]  = '{5'd4,  932,  4'd4, 2'd1};
        tbl[10] = '{5'd31, 0,    4'd0, 2'd0};
        tbl[11] = '{5'd22, 0,    4'd0, 2'd0};

        #1 RST = 1'b0;
        #1;
        chk("reset spks", int'(SPKS), 0);
        chk("reset beat", int'(BEAT), 0);
        chk("reset code", int'(CODE), 0);
        chk("reset high", int'(HIGH), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        beat_seq("init");

        foreach (tbl[i]) begin
            TONE_CODE = tbl[i].code;
            wait_latch();
            if (tbl[i].half == 0) begin
                chk($sformatf("rest %0d spks after latch", tbl[i].code), int'(SPKS), 0);
                quiet = 1'b1;
                repeat (40) begin
                    @(negedge CLK);
                    if (SPKS !== 1'b0) quiet = 1'b0;
                end
                chk($sformatf("rest %0d stays quiet", tbl[i].code), int'(quiet), 1);
            end else begin
                wait_toggle(n);
                wait_toggle(n);
                chk($sformatf("code %0d half period", tbl[i].code), n, tbl[i].half);
            end
            chk($sformatf("code %0d CODE", tbl[i].code), int'(CODE), DISP ? int'(tbl[i].c) : 0);
            chk($sformatf("code %0d HIGH", tbl[i].code), int'(HIGH), DISP ? int'(tbl[i].h) : 0);
        end

        TONE_CODE = 5'd1;
        wait_latch();
        wait_toggle(n);
        wait_toggle(n);
        t0 = cyc;
        repeat (100) @(negedge CLK);
        TONE_CODE = 5'd21;
        wait_latch();
        wait_toggle(n);
        chk("change 1->21 running half", cyc - t0, 1275);
        wait_toggle(n);
        chk("change 1->21 new half a", n, 61);
        wait_toggle(n);
        chk("change 1->21 new half b", n, 61);

        TONE_CODE = 5'd8;
        wait_latch();
        tries = 0;
        while (SPKS !== 1'b1 && tries < 3) begin
            wait_toggle(n);
            tries++;
        end
        chk("spks high before reset", int'(SPKS), 1);
        #2 RST = 1'b0;
        #1;
        chk("mid-note reset spks", int'(SPKS), 0);
        chk("mid-note reset beat", int'(BEAT), 0);
        chk("mid-note reset code", int'(CODE), 0);
        chk("mid-note reset high", int'(HIGH), 0);
        repeat (3) @(negedge CLK);
        chk("held reset spks", int'(SPKS), 0);
        RST = 1'b1;
        beat_seq("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter BEAT_DIV, default 3000000, gives CLK cycles per beat (12 MHz clock -> 4 Hz beat); legal values are 2 or more.
REQ-002 Parameter PRE_DIV, default 12, gives CLK cycles per tone-base tick (12 MHz -> 1 MHz); legal values are 1 or more.
REQ-003 Port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port TONE_CODE, input, 5 bits: note code read from the note-data ROM at the current song address.
REQ-006 Port BEAT, output, 1 bit: one-CLK pulse per beat; it steps the song address counter and latches TONE_CODE.
REQ-007 Port SPKS, output, 1 bit: square-wave speaker drive.
REQ-008 Port CODE, output, 4 bits: display digit for the current note, 0 to 7 (0 = rest).
REQ-009 Port HIGH, output, 2 bits: octave indicator (00 = rest, 01 = low, 10 = mid, 11 = high).

Function
REQ-010 The beat counter shall count from 0 to BEAT_DIV-1 and then wrap to 0.
REQ-011 BEAT shall be 1 exactly in the cycle where the beat counter equals BEAT_DIV-1.
REQ-012 In the cycle after BEAT=1, the note register shall hold the TONE_CODE value sampled at that edge; at all other times it holds its value.
REQ-013 Code mapping:
- 0 = rest
- 1 to 7 = low do to ti
- 8 to 14 = mid do to ti
- 15 to 21 = high do to ti
- 22 to 31 = rest
REQ-014 The 11-bit preset, combinational from the note register, shall be:
- low, codes 1-7: 773, 912, 1036, 1116, 1197, 1290, 1372
- mid, codes 8-14: 1410, 1480, 1542, 1622, 1668, 1728, 1774
- high, codes 15-21: 1813, 1854, 1891, 1905, 1934, 1961, 1987
- rest codes: 2047
REQ-015 The prescaler shall count from 0 to PRE_DIV-1 and assert a one-cycle tick at PRE_DIV-1.
REQ-016 On each tick, the 11-bit tone counter shall load the preset if it equals 2047; otherwise it shall increment by 1.
REQ-017 Each tone-counter load on a non-rest note shall toggle SPKS.
- Output frequency = (CLK/PRE_DIV) / (2*(2048-preset)).
REQ-018 A new note's preset shall take effect only at the next tone-counter load; a note change never truncates a running period.
REQ-019 While the note register holds a rest code:
- SPKS shall be 0 from the cycle after the latch.
- The tone counter shall be held at 2047.
- So the first tick after leaving rest loads the new preset.
REQ-020 If the same code is latched again, the SPKS phase shall continue undisturbed.
REQ-021 When BEAT and a tick occur in the same cycle, the tick shall use the old note register; the new note applies from the next tick.
REQ-022 CODE and HIGH shall be registered from the note register; they update in the cycle after the note register changes.

Reset
REQ-023 While RST=0, every register shall clear asynchronously:
- beat counter = 0, prescaler = 0, tone counter = 2047
- note register = 0
- SPKS = 0, BEAT = 0, CODE = 0, HIGH = 00
REQ-024 Reset asserted mid-note shall silence SPKS immediately, with no clock needed.
REQ-025 After RST returns to 1, the first BEAT shall occur at the BEAT_DIV-th rising edge.

Configuration
REQ-026 Macro TONE_DISPLAY_EN selects the display path:
- Defined: CODE and HIGH behave per REQ-008, REQ-009 and REQ-022.
- Undefined: the display registers are not built; CODE drives constant 0 and HIGH drives constant 00, and ports are unchanged.
- Tone behaviour is identical in both builds.

Verification
REQ-027 Beat timing, BEAT_DIV=8, PRE_DIV=1, after reset release: BEAT pulses at edges 8, 16, 24, each 1 cycle wide.
REQ-028 Mid tone, TONE_CODE=8 latched (preset 1410): SPKS period = 2*(2048-1410) = 1276 CLK cycles; with the macro defined, CODE=1 and HIGH=10.
REQ-029 Rest, TONE_CODE=0 or 25 latched while a note is sounding: SPKS=0 from the next cycle and stays 0; CODE=0 and HIGH=00.
REQ-030 Note change, code 1 then code 21 on consecutive beats: the current half-period completes at preset 773, then half-periods of 61 cycles follow; no short pulse.
REQ-031 Reset mid-note, RST low for 3 cycles while SPKS=1: SPKS=0 asynchronously; all outputs at reset values; beat restarts at edge 8.
REQ-032 Build without TONE_DISPLAY_EN, TONE_CODE=15: CODE=0 and HIGH=00 constantly; SPKS period = 2*(2048-1813) = 470 cycles.
